// File: rtl/display_scanner.sv
// Multiplexed BCD display scanner: walks the digit enables slot by slot, blanks the
// start of each slot, and swaps in new values only at frame boundaries.
module display_scanner #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic                    load,
    input  logic                    lz_blank,
    output logic [3:0]              digit,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam int SW = $clog2(NUM_DIGITS);
    localparam int AW = 4 * NUM_DIGITS;

    logic [CW-1:0] cnt, cnt_nxt;
    logic [SW-1:0] sel, sel_nxt;
    logic [AW-1:0] shadow, shadow_nxt;
    logic [AW-1:0] active, active_nxt;
    logic          pending, pending_nxt;

    logic          cnt_wrap, sel_wrap, boundary;
    logic [NUM_DIGITS-1:0] upper_zero;
    logic [3:0]    nib_nxt;
    logic          blank_nxt;
    logic          in_blank;
    logic [3:0]    digit_nxt;
    logic [NUM_DIGITS-1:0] an_nxt;

    always_comb begin
        cnt_wrap = (cnt == CW'(REFRESH_DIV - 1));
        sel_wrap = (sel == SW'(NUM_DIGITS - 1));
        boundary = cnt_wrap & sel_wrap;

        cnt_nxt = cnt_wrap ? '0 : cnt + 1'b1;
        if (cnt_wrap)
            sel_nxt = sel_wrap ? '0 : sel + 1'b1;
        else
            sel_nxt = sel;

        // A load landing exactly on the boundary bypasses the shadow stage.
        if (boundary && load)
            active_nxt = bcd_in;
        else if (boundary && pending)
            active_nxt = shadow;
        else
            active_nxt = active;

        shadow_nxt = load ? bcd_in : shadow;
        if (load)
            pending_nxt = ~boundary;
        else if (boundary)
            pending_nxt = 1'b0;
        else
            pending_nxt = pending;
    end

    // upper_zero[i]: nibbles i..NUM_DIGITS-1 of the next active value are all zero.
    always_comb begin
        upper_zero = '0;
        upper_zero[NUM_DIGITS-1] = (active_nxt[AW-1 -: 4] == 4'h0);
        for (int i = NUM_DIGITS - 2; i >= 0; i--)
            upper_zero[i] = upper_zero[i+1] & (active_nxt[i*4 +: 4] == 4'h0);
    end

    always_comb begin
        nib_nxt   = 4'h0;
        blank_nxt = 1'b0;
        an_nxt    = '1;
        in_blank  = (cnt_nxt < CW'(BLANK_CYC));
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sel_nxt == SW'(i)) begin
                nib_nxt   = active_nxt[i*4 +: 4];
                blank_nxt = lz_blank && (i > 0) && upper_zero[i];
                an_nxt[i] = in_blank;
            end
        end
        digit_nxt = (in_blank || blank_nxt) ? 4'hF : nib_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            sel        <= '0;
            shadow     <= '0;
            active     <= '0;
            pending    <= 1'b0;
            an         <= '1;
            digit      <= 4'hF;
            frame_done <= 1'b0;
        end else begin
            cnt        <= cnt_nxt;
            sel        <= sel_nxt;
            shadow     <= shadow_nxt;
            active     <= active_nxt;
            pending    <= pending_nxt;
            an         <= an_nxt;
            digit      <= digit_nxt;
            frame_done <= boundary;
        end
    end

endmodule

// File: tb/tb_display_scanner.sv
// Randomised bench for display_scanner, checked against a cycle-indexed arithmetic model.
module tb_display_scanner;

    localparam int ND = 4;
    localparam int RD = 4;
    localparam int BC = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] bcd_in = '0;
    logic        load = 1'b0;
    logic        lz_blank = 1'b0;
    logic [3:0]  digit;
    logic [3:0]  an;
    logic        frame_done;

    display_scanner #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYC(BC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bcd_in     (bcd_in),
        .load       (load),
        .lz_blank   (lz_blank),
        .digit      (digit),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // model: t = cycles since reset release
    int          t = 0;
    logic [15:0] m_active = '0;
    logic [15:0] m_shadow = '0;
    bit          m_pending = 1'b0;
    bit          m_lz = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0d got=%0h exp=%0h", tag, t, got, exp);
        end
    endtask

    task automatic check_outputs();
        int c, s;
        logic [3:0] ea, ed;
        c = t % RD;
        s = (t / RD) % ND;
        if (c < BC) begin
            ea = 4'hF;
            ed = 4'hF;
        end else begin
            ea = ~(4'b0001 << s);
            ed = 4'((m_active >> (s * 4)) & 16'hF);
            if (m_lz && s > 0 && (m_active >> (s * 4)) == 16'h0)
                ed = 4'hF;
        end
        check("an", 32'(an), 32'(ea));
        check("digit", 32'(digit), 32'(ed));
        check("frame_done", 32'(frame_done), (t > 0 && c == 0 && s == 0) ? 32'd1 : 32'd0);
    endtask

    function automatic bit at_boundary();
        return (t % RD == RD - 1) && ((t / RD) % ND == ND - 1);
    endfunction

    // drive one cycle of inputs, advance the model, then check the next cycle
    task automatic step(input bit ld, input logic [15:0] v, input bit lz);
        bit b;
        b = at_boundary();
        load = ld;
        bcd_in = v;
        lz_blank = lz;
        if (ld) begin
            m_shadow = v;
            if (b) begin
                m_active = v;
                m_pending = 1'b0;
            end else begin
                m_pending = 1'b1;
            end
        end else if (b && m_pending) begin
            m_active = m_shadow;
            m_pending = 1'b0;
        end
        m_lz = lz;
        t++;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset();
        load = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_an", 32'(an), 32'hF);
        check("rst_digit", 32'(digit), 32'hF);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        t = 0;
        m_active = '0;
        m_shadow = '0;
        m_pending = 1'b0;
        m_lz = 1'b0;
        check_outputs();
    endtask

    function automatic logic [15:0] rnd_bcd();
        logic [15:0] v;
        v = '0;
        for (int i = 0; i < 4; i++)
            if ($urandom_range(0, 2) != 0)
                v[i*4 +: 4] = 4'($urandom_range(0, 15));
        return v;
    endfunction

    initial begin
        bit lz;
        bit ld;
        #2;
        do_reset();

        // free run from reset, no load
        for (int i = 0; i < 20; i++) step(1'b0, 16'h0, 1'b0);

        // load mid-frame, shown from next frame
        do_reset();
        for (int i = 0; i < 36; i++) step(t == 2, 16'h1234, 1'b0);

        // leading-zero blanking on and off
        do_reset();
        for (int i = 0; i < 52; i++) step(t == 0, 16'h0050, (t >= 16 && t < 36));

        // shadow overwrite, then load exactly on a boundary
        do_reset();
        for (int i = 0; i < 64; i++) begin
            if (t == 5)       step(1'b1, 16'h1111, 1'b0);
            else if (t == 9)  step(1'b1, 16'h2222, 1'b0);
            else if (t == 31) step(1'b1, 16'h3333, 1'b0);
            else              step(1'b0, 16'h0, 1'b0);
        end

        // nonzero nibble above 9 stops blanking, then reset mid-slot
        do_reset();
        for (int i = 0; i < 40; i++) step(t == 3, 16'hA000, 1'b1);
        @(posedge clk);
        #3;
        do_reset();
        for (int i = 0; i < 20; i++) step(1'b0, 16'h0, 1'b1);

        // random traffic with occasional resets and forced boundary loads
        lz = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (n % 700 == 350) do_reset();
            if ($urandom_range(0, 19) == 0) lz = ~lz;
            ld = ($urandom_range(0, 7) == 0) || (at_boundary() && $urandom_range(0, 2) == 0);
            step(ld, rnd_bcd(), lz);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/display_scanner.md
DISPLAY_SCANNER -- requirements
Module: display_scanner

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of multiplexed digits (2..8).
REQ-002 Parameter REFRESH_DIV, default 50000, clock cycles per digit slot (>= BLANK_CYC+2).
REQ-003 Parameter BLANK_CYC, default 16, anti-ghosting cycles at the start of each slot (>= 1).
REQ-004 clk  input  1  system clock, rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low; one clock, no other reset.
REQ-006 bcd_in  input  4*NUM_DIGITS  packed BCD value; bits [3:0] = digit 0 (least significant).
REQ-007 load  input  1  single-cycle strobe; captures bcd_in.
REQ-008 lz_blank  input  1  1 = blank leading zeros.
REQ-009 digit  output  4  code for the downstream 7-segment decoder; 4'hF = blank (decoder drives all segments off).
REQ-010 an  output  NUM_DIGITS  digit enables, active-low, at most one low.
REQ-011 frame_done  output  1  one-cycle pulse at start of each frame.

Function
REQ-012 The design SHALL hold slot counter cnt (0..REFRESH_DIV-1) and digit select sel (0..NUM_DIGITS-1).
REQ-013 cnt SHALL increment every cycle; at REFRESH_DIV-1 it SHALL wrap to 0 and sel SHALL advance by 1, wrapping NUM_DIGITS-1 -> 0.
REQ-014 All outputs SHALL be registered and decoded from next-state values, so an/digit correspond to the current cnt/sel with zero lag.
REQ-015 an[sel] SHALL be 0 only while cnt >= BLANK_CYC; all other an bits and all bits during cnt < BLANK_CYC SHALL be 1.
REQ-016 digit SHALL equal active[sel] nibble, or 4'hF if that digit is blanked; digit SHALL be 4'hF while cnt < BLANK_CYC.
REQ-017 load=1 SHALL copy bcd_in into the shadow register and set pending=1; a later load before the frame boundary SHALL overwrite shadow.
REQ-018 Frame boundary = cycle where cnt=REFRESH_DIV-1 and sel=NUM_DIGITS-1; at that edge, if pending, active <= shadow and pending <= 0.
REQ-019 load coincident with a frame boundary SHALL write bcd_in directly into active (bypass), leave pending=0.
REQ-020 frame_done SHALL be 1 exactly in the cycle with cnt=0, sel=0 following a frame boundary; 0 otherwise.
REQ-021 Leading-zero blanking (lz_blank=1): digit i SHALL be blanked iff i>0 and active nibbles i..NUM_DIGITS-1 are all 4'h0; digit 0 is never blanked.
REQ-022 lz_blank SHALL be sampled every cycle (not latched); with lz_blank=0 no digit is blanked by this rule.
REQ-023 Nibbles > 9 SHALL pass to digit unmodified and count as nonzero for blanking.
REQ-024 The active register SHALL never change except at a frame boundary (no mid-frame tearing).

Reset
REQ-025 While rst_n=0: cnt=0, sel=0, shadow=0, active=0, pending=0, an=all 1s, digit=4'hF, frame_done=0.
REQ-026 Reset assertion mid-frame SHALL discard pending and active immediately; first cycle after release is cnt=0, sel=0 with frame_done=0.

Verification (NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYC=1)
REQ-027 Reset release, no load -> an cycles 1111,1110,1110,1110,1111,1101,... digit F,0,0,0,F,0,...; frame_done first pulses at cycle 16.
REQ-028 load bcd_in=16'h1234 at cycle 2, lz_blank=0 -> digits stay 0 until cycle 16, then slots show 4,3,2,1.
REQ-029 active=16'h0050, lz_blank=1 -> slot0 0, slot1 5, slots 2-3 digit F with an bits low but segments blank; lz_blank=0 -> 0,5,0,0.
REQ-030 load 16'h1111 at cycle 5 and 16'h2222 at cycle 9 -> next frame shows 2222; load 16'h3333 at a boundary cycle -> 3333 in the immediately following frame.
REQ-031 active=16'hA000, lz_blank=1 -> digits 0,0,0,A shown (no blanking); rst_n pulsed low mid-slot -> an=1111, digit=F asynchronously, active reads 0 after release.
